// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sweep scheduler.
package dds_pkg;

   localparam int N_DEF    = 32;
   localparam int M_DEF    = 12;
   localparam int DW_W_DEF = 16;

   localparam logic [3:0] WAVE_SIN = 4'b0001;
   localparam logic [3:0] WAVE_SQU = 4'b0010;
   localparam logic [3:0] WAVE_TRI = 4'b0100;
   localparam logic [3:0] WAVE_SAW = 4'b1000;

   localparam logic [1:0] MODE_SINGLE     = 2'b00;
   localparam logic [1:0] MODE_REPEAT     = 2'b01;
   localparam logic [1:0] MODE_TRI        = 2'b10;
   localparam logic [1:0] MODE_SINGLE_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// Combinational clamped step: one extra bit catches carry/borrow so the
// ramp never wraps past either endpoint.
module dds_sweep_step
   import dds_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         i_dir,
   input  logic [N-1:0] i_cur,
   input  logic [N-1:0] i_inc,
   input  logic [N-1:0] i_lo,
   input  logic [N-1:0] i_hi,
   output logic [N-1:0] o_next,
   output logic         o_last
);

   logic [N:0] w_sum;
   logic [N:0] w_diff;
   logic       w_up_last;
   logic       w_dn_last;

   assign w_sum     = {1'b0, i_cur} + {1'b0, i_inc};
   assign w_diff    = {1'b0, i_cur} - {1'b0, i_inc};
   assign w_up_last = w_sum[N]  | (w_sum[N-1:0]  >= i_hi);
   assign w_dn_last = w_diff[N] | (w_diff[N-1:0] <= i_lo);

   always_comb begin
      o_next = w_sum[N-1:0];
      o_last = w_up_last;
      if (i_dir) begin
         o_last = w_dn_last;
         o_next = w_dn_last ? i_lo : w_diff[N-1:0];
      end else if (w_up_last) begin
         o_next = i_hi;
      end
   end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: latches a sweep config on start and ramps
// fre_step between f_start and f_stop, holding each value dwell+1 cycles.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int M    = M_DEF,
   parameter int DW_W = DW_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [1:0]      mode,
   input  logic [3:0]      wave_sel_in,
   input  logic [M-1:0]    pha_in,
   input  logic [N-1:0]    f_start,
   input  logic [N-1:0]    f_stop,
   input  logic [N-1:0]    f_inc,
   input  logic [DW_W-1:0] dwell,
   output logic [N-1:0]    fre_step,
   output logic [M-1:0]    pha_step,
   output logic [3:0]      wave_sel,
   output logic            busy,
   output logic            done,
   output logic            dir,
   output logic [1:0]      state_dbg
);

   sweep_state_t    r_state;
   sweep_state_t    w_state_nxt;
   logic [N-1:0]    r_fre;
   logic [M-1:0]    r_pha;
   logic [3:0]      r_wave;
   logic            r_done;
   logic            r_dir;
   logic [1:0]      r_mode;
   logic [N-1:0]    r_f_start;
   logic [N-1:0]    r_f_stop;
   logic [N-1:0]    r_f_inc;
   logic [DW_W-1:0] r_dwell;
   logic [DW_W-1:0] r_cnt;
   logic            r_last;
   logic            r_degen;

   logic            w_load;
   logic            w_adv;
   logic            w_turn;
   logic            w_wrap;
   logic            w_finish;
   logic            w_dwell_end;
   logic            w_degen_in;
   logic            w_step_dir;
   logic [N-1:0]    w_step_next;
   logic            w_step_last;

   assign w_dwell_end = (r_cnt == r_dwell);
   assign w_degen_in  = (f_inc == '0) || (f_start >= f_stop);
   // Once the current value is an endpoint, the next step goes the other way.
   assign w_step_dir  = r_last ? ~r_dir : r_dir;

   dds_sweep_step #(.N(N)) u_step (
      .i_dir  (w_step_dir),
      .i_cur  (r_fre),
      .i_inc  (r_f_inc),
      .i_lo   (r_f_start),
      .i_hi   (r_f_stop),
      .o_next (w_step_next),
      .o_last (w_step_last)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_turn      = 1'b0;
      w_wrap      = 1'b0;
      w_finish    = 1'b0;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_UP;
               end
            end
            ST_UP: begin
               if (w_dwell_end) begin
                  if (!r_last) begin
                     w_adv = 1'b1;
                  end else if (!r_degen && r_mode == MODE_REPEAT) begin
                     w_wrap = 1'b1;
                  end else if (!r_degen && r_mode == MODE_TRI) begin
                     w_turn      = 1'b1;
                     w_state_nxt = ST_DOWN;
                  end else begin
                     w_finish    = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            ST_DOWN: begin
               if (w_dwell_end) begin
                  if (!r_last) begin
                     w_adv = 1'b1;
                  end else begin
                     w_turn      = 1'b1;
                     w_state_nxt = ST_UP;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fre     <= '0;
         r_pha     <= '0;
         r_wave    <= WAVE_SIN;
         r_done    <= 1'b0;
         r_dir     <= 1'b0;
         r_mode    <= MODE_SINGLE;
         r_f_start <= '0;
         r_f_stop  <= '0;
         r_f_inc   <= '0;
         r_dwell   <= '0;
         r_cnt     <= '0;
         r_last    <= 1'b0;
         r_degen   <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load || abort) begin
            r_cnt <= '0;
         end else if (r_state != ST_IDLE) begin
            r_cnt <= w_dwell_end ? '0 : r_cnt + 1'b1;
         end
         if (w_load) begin
            r_mode    <= mode;
            r_wave    <= wave_sel_in;
            r_pha     <= pha_in;
            r_f_start <= f_start;
            r_f_stop  <= f_stop;
            r_f_inc   <= f_inc;
            r_dwell   <= dwell;
            r_fre     <= f_start;
            r_dir     <= 1'b0;
            r_last    <= w_degen_in;
            r_degen   <= w_degen_in;
         end
         if (w_adv || w_turn) begin
            r_fre  <= w_step_next;
            r_last <= w_step_last;
         end
         if (w_turn) r_dir <= ~r_dir;
         // Non-degenerate config guarantees f_start is not itself the last value.
         if (w_wrap) begin
            r_fre  <= r_f_start;
            r_last <= 1'b0;
         end
      end
   end

   assign fre_step  = r_fre;
   assign pha_step  = r_pha;
   assign wave_sel  = r_wave;
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign dir       = r_dir;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: table of single-shot sweeps plus
// hand-written repeat, triangle, abort, reset and busy-start sequences.
module tb_dds_sweep_ctrl;
   import dds_pkg::*;

   localparam int N    = 32;
   localparam int M    = 12;
   localparam int DW_W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            abort;
   logic [1:0]      mode;
   logic [3:0]      wave_sel_in;
   logic [M-1:0]    pha_in;
   logic [N-1:0]    f_start;
   logic [N-1:0]    f_stop;
   logic [N-1:0]    f_inc;
   logic [DW_W-1:0] dwell;
   logic [N-1:0]    fre_step;
   logic [M-1:0]    pha_step;
   logic [3:0]      wave_sel;
   logic            busy;
   logic            done;
   logic            dir;
   logic [1:0]      state_dbg;

   int           n_total = 0;
   int           n_bad   = 0;
   logic [N:0]   exp_q[$];
   logic [3:0]   exp_wave;
   logic [M-1:0] exp_pha;

   typedef struct {
      logic [1:0]   md;
      logic [N-1:0] fs;
      logic [N-1:0] fe;
      logic [N-1:0] inc;
      int           dw;
      int           nv;
      logic [N-1:0] v[4];
   } vec_t;
   vec_t vecs[8];

   dds_sweep_ctrl #(.N(N), .M(M), .DW_W(DW_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .mode        (mode),
      .wave_sel_in (wave_sel_in),
      .pha_in      (pha_in),
      .f_start     (f_start),
      .f_stop      (f_stop),
      .f_inc       (f_inc),
      .dwell       (dwell),
      .fre_step    (fre_step),
      .pha_step    (pha_step),
      .wave_sel    (wave_sel),
      .busy        (busy),
      .done        (done),
      .dir         (dir),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int idx, input logic [1:0] md, input logic [N-1:0] fs,
                          input logic [N-1:0] fe, input logic [N-1:0] inc, input int dw,
                          input int nv, input logic [N-1:0] v0, input logic [N-1:0] v1,
                          input logic [N-1:0] v2, input logic [N-1:0] v3);
      vecs[idx].md   = md;
      vecs[idx].fs   = fs;
      vecs[idx].fe   = fe;
      vecs[idx].inc  = inc;
      vecs[idx].dw   = dw;
      vecs[idx].nv   = nv;
      vecs[idx].v[0] = v0;
      vecs[idx].v[1] = v1;
      vecs[idx].v[2] = v2;
      vecs[idx].v[3] = v3;
   endtask

   // Drives config and a one-cycle start; returns #1 after the sampling edge.
   task automatic drive_start(input logic [1:0] md, input logic [N-1:0] fs, input logic [N-1:0] fe,
                              input logic [N-1:0] inc, input int dw);
      mode        = md;
      f_start     = fs;
      f_stop      = fe;
      f_inc       = inc;
      dwell       = DW_W'(dw);
      wave_sel_in = 4'b0001 << $urandom_range(0, 3);
      pha_in      = M'($urandom_range(0, 4095));
      exp_wave    = wave_sel_in;
      exp_pha     = pha_in;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic push_vals(input logic [N-1:0] v, input logic d, input int dw);
      repeat (dw + 1) exp_q.push_back({d, v});
   endtask

   // Pops one expected {dir, fre} per cycle; optionally fires a start while busy.
   task automatic check_sweep(input string tag, input bit exp_finish, input int busy_start_at);
      int         i;
      logic [N:0] e;
      i = 0;
      while (exp_q.size() > 0) begin
         start = 1'b0;
         e = exp_q.pop_front();
         chk({tag, " fre"},  64'(fre_step), 64'(e[N-1:0]));
         chk({tag, " dir"},  64'(dir),      64'(e[N]));
         chk({tag, " busy"}, 64'(busy),     64'd1);
         chk({tag, " done"}, 64'(done),     64'd0);
         chk({tag, " wave"}, 64'(wave_sel), 64'(exp_wave));
         chk({tag, " pha"},  64'(pha_step), 64'(exp_pha));
         if (i == busy_start_at) begin
            mode        = MODE_TRI;
            f_start     = 32'd0;
            f_stop      = 32'd1000;
            f_inc       = 32'd1;
            dwell       = '0;
            wave_sel_in = (exp_wave == WAVE_SAW) ? WAVE_SIN : WAVE_SAW;
            pha_in      = ~exp_pha;
            start       = 1'b1;
         end
         @(posedge clk); #1;
         i++;
      end
      start = 1'b0;
      if (exp_finish) begin
         chk({tag, " done_pulse"}, 64'(done), 64'd1);
         chk({tag, " busy_end"},   64'(busy), 64'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " fre"},   64'(fre_step),  64'd0);
      chk({tag, " pha"},   64'(pha_step),  64'd0);
      chk({tag, " wave"},  64'(wave_sel),  64'(WAVE_SIN));
      chk({tag, " busy"},  64'(busy),      64'd0);
      chk({tag, " done"},  64'(done),      64'd0);
      chk({tag, " dir"},   64'(dir),       64'd0);
      chk({tag, " state"}, 64'(state_dbg), 64'(ST_IDLE));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; wave_sel_in = '0; pha_in = '0;
      f_start = '0; f_stop = '0; f_inc = '0; dwell = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      set_vec(0, MODE_SINGLE,     32'd100, 32'd130, 32'd10, 2, 4, 32'd100, 32'd110, 32'd120, 32'd130);
      set_vec(1, MODE_SINGLE,     32'd100, 32'd125, 32'd10, 2, 4, 32'd100, 32'd110, 32'd120, 32'd125);
      set_vec(2, MODE_SINGLE,     32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd32, 0, 2,
              32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
      set_vec(3, MODE_SINGLE,     32'd50,  32'd80,  32'd0,  1, 1, 32'd50,  32'd0, 32'd0, 32'd0);
      set_vec(4, MODE_SINGLE,     32'd200, 32'd150, 32'd5,  0, 1, 32'd200, 32'd0, 32'd0, 32'd0);
      set_vec(5, MODE_SINGLE_ALT, 32'd0,   32'd7,   32'd3,  1, 4, 32'd0,   32'd3, 32'd6, 32'd7);
      set_vec(6, MODE_TRI,        32'd10,  32'd10,  32'd1,  0, 1, 32'd10,  32'd0, 32'd0, 32'd0);
      set_vec(7, MODE_REPEAT,     32'd5,   32'd100, 32'd0,  2, 1, 32'd5,   32'd0, 32'd0, 32'd0);

      for (int k = 0; k < 8; k++) begin
         drive_start(vecs[k].md, vecs[k].fs, vecs[k].fe, vecs[k].inc, vecs[k].dw);
         for (int j = 0; j < vecs[k].nv; j++) push_vals(vecs[k].v[j], 1'b0, vecs[k].dw);
         check_sweep($sformatf("vec%0d", k), 1'b1, -1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d done_clear", k), 64'(done), 64'd0);
         chk($sformatf("vec%0d fre_hold", k), 64'(fre_step), 64'(vecs[k].v[vecs[k].nv - 1]));
      end

      // Start accepted in the same cycle done is high.
      drive_start(MODE_SINGLE, 32'd100, 32'd130, 32'd10, 0);
      push_vals(32'd100, 1'b0, 0); push_vals(32'd110, 1'b0, 0);
      push_vals(32'd120, 1'b0, 0); push_vals(32'd130, 1'b0, 0);
      check_sweep("b2b_a", 1'b1, -1);
      drive_start(MODE_SINGLE, 32'd5, 32'd20, 32'd5, 0);
      push_vals(32'd5, 1'b0, 0);  push_vals(32'd10, 1'b0, 0);
      push_vals(32'd15, 1'b0, 0); push_vals(32'd20, 1'b0, 0);
      check_sweep("b2b_b", 1'b1, -1);
      @(posedge clk); #1;

      // New config presented with start while busy must be ignored.
      drive_start(MODE_SINGLE, 32'd100, 32'd130, 32'd10, 1);
      push_vals(32'd100, 1'b0, 1); push_vals(32'd110, 1'b0, 1);
      push_vals(32'd120, 1'b0, 1); push_vals(32'd130, 1'b0, 1);
      check_sweep("busy_start", 1'b1, 2);
      @(posedge clk); #1;

      // Repeat sawtooth: wraps to f_start, never pulses done.
      drive_start(MODE_REPEAT, 32'd100, 32'd120, 32'd10, 0);
      for (int r = 0; r < 2; r++) begin
         push_vals(32'd100, 1'b0, 0); push_vals(32'd110, 1'b0, 0); push_vals(32'd120, 1'b0, 0);
      end
      push_vals(32'd100, 1'b0, 0);
      check_sweep("repeat", 1'b0, -1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("repeat abort busy", 64'(busy), 64'd0);
      chk("repeat abort done", 64'(done), 64'd0);
      chk("repeat abort fre",  64'(fre_step), 64'd110);

      // Triangle: endpoints visited once per turnaround.
      drive_start(MODE_TRI, 32'd100, 32'd120, 32'd10, 0);
      push_vals(32'd100, 1'b0, 0); push_vals(32'd110, 1'b0, 0); push_vals(32'd120, 1'b0, 0);
      push_vals(32'd110, 1'b1, 0); push_vals(32'd100, 1'b1, 0);
      push_vals(32'd110, 1'b0, 0); push_vals(32'd120, 1'b0, 0); push_vals(32'd110, 1'b1, 0);
      check_sweep("tri", 1'b0, -1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("tri abort busy", 64'(busy), 64'd0);
      chk("tri abort done", 64'(done), 64'd0);
      chk("tri abort fre",  64'(fre_step), 64'd100);
      chk("tri abort dir",  64'(dir), 64'd1);

      // Abort during the 110 dwell.
      drive_start(MODE_SINGLE, 32'd100, 32'd130, 32'd10, 2);
      push_vals(32'd100, 1'b0, 2);
      exp_q.push_back({1'b0, 32'd110});
      check_sweep("abort", 1'b0, -1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort busy",  64'(busy), 64'd0);
      chk("abort fre",   64'(fre_step), 64'd110);
      chk("abort done",  64'(done), 64'd0);
      chk("abort state", 64'(state_dbg), 64'(ST_IDLE));
      @(posedge clk); #1;
      chk("abort done_late", 64'(done), 64'd0);
      chk("abort fre_late",  64'(fre_step), 64'd110);

      // Start and abort together from IDLE: abort wins.
      f_start = 32'd500; f_stop = 32'd600; f_inc = 32'd1; mode = MODE_SINGLE;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("same_cycle busy",  64'(busy), 64'd0);
      chk("same_cycle fre",   64'(fre_step), 64'd110);
      chk("same_cycle state", 64'(state_dbg), 64'(ST_IDLE));
      @(posedge clk); #1;
      chk("same_cycle busy_late", 64'(busy), 64'd0);

      // Reset mid-sweep, then a fresh sweep still works.
      drive_start(MODE_TRI, 32'd100, 32'd200, 32'd10, 1);
      push_vals(32'd100, 1'b0, 1); push_vals(32'd110, 1'b0, 1);
      check_sweep("pre_rst", 1'b0, -1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_reset_vals("mid_rst");
      drive_start(MODE_SINGLE, 32'd1, 32'd3, 32'd1, 0);
      push_vals(32'd1, 1'b0, 0); push_vals(32'd2, 1'b0, 0); push_vals(32'd3, 1'b0, 0);
      check_sweep("post_rst", 1'b1, -1);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
